// File: rtl/blocpu_program_loader_if.sv
// rtl/blocpu_program_loader_if.sv - UART byte, reply and core instruction-port bundle for the program loader
interface blocpu_program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        core_running_status;
    logic        core_reset;
    logic        core_running;
    logic [11:0] instr;
    logic [15:0] instr_addr;
    logic        instr_write;
    logic        loading;

    modport master (
        input  rx_valid, rx_data, tx_busy, core_running_status,
        output tx_start, tx_data, core_reset, core_running,
               instr, instr_addr, instr_write, loading
    );

    modport slave (
        output rx_valid, rx_data, tx_busy, core_running_status,
        input  tx_start, tx_data, core_reset, core_running,
               instr, instr_addr, instr_write, loading
    );
endinterface

// File: rtl/blocpu_program_loader.sv
// rtl/blocpu_program_loader.sv - serial command decoder, instruction-memory loader and run control for blocpu_core
module blocpu_program_loader #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    blocpu_program_loader_if.master   bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_CHECKSUM, S_RESPOND
    } state_t;

    localparam logic [7:0] CMD_LOAD      = 8'hA5;
    localparam logic [7:0] CMD_RUN       = 8'h52;
    localparam logic [7:0] CMD_STOP      = 8'h53;
    localparam logic [7:0] CMD_RESET     = 8'h58;
    localparam logic [7:0] CMD_STATUS    = 8'h3F;
    localparam logic [7:0] REPLY_OK      = 8'h4B;
    localparam logic [7:0] REPLY_UNKNOWN = 8'h45;
    localparam logic [7:0] REPLY_CSUM    = 8'h43;
    localparam logic [7:0] REPLY_TIMEOUT = 8'h54;

    // Counter only has to hold TIMEOUT_CYCLES-1; expiry fires as it would step past it.
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_d;
    logic [15:0]   len, len_d;
    logic [15:0]   addr, addr_d;
    logic [15:0]   addr_inc;
    logic [3:0]    hi_nib, hi_nib_d;
    logic [7:0]    csum, csum_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [7:0]    reply, reply_d;
    logic          tx_start, tx_start_d;
    logic [7:0]    tx_data, tx_data_d;
    logic          core_reset, core_reset_d;
    logic          core_running, core_running_d;
    logic          loading, loading_d;
    logic [11:0]   instr, instr_d;
    logic [15:0]   instr_addr, instr_addr_d;
    logic          timed;

    assign addr_inc = addr + 16'd1;
    assign timed = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                   (state == S_DATA_LO) || (state == S_CHECKSUM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            len          <= '0;
            addr         <= '0;
            hi_nib       <= '0;
            csum         <= '0;
            tmo          <= '0;
            reply        <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            core_reset   <= 1'b1;
            core_running <= 1'b0;
            loading      <= 1'b0;
            instr        <= '0;
            instr_addr   <= '0;
        end else begin
            state        <= state_d;
            len          <= len_d;
            addr         <= addr_d;
            hi_nib       <= hi_nib_d;
            csum         <= csum_d;
            tmo          <= tmo_d;
            reply        <= reply_d;
            tx_start     <= tx_start_d;
            tx_data      <= tx_data_d;
            core_reset   <= core_reset_d;
            core_running <= core_running_d;
            loading      <= loading_d;
            instr        <= instr_d;
            instr_addr   <= instr_addr_d;
        end
    end

    always_comb begin
        state_d        = state;
        len_d          = len;
        addr_d         = addr;
        hi_nib_d       = hi_nib;
        csum_d         = csum;
        tmo_d          = '0;
        reply_d        = reply;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data;
        core_reset_d   = core_reset;
        core_running_d = core_running;
        loading_d      = loading;
        instr_d        = instr;
        instr_addr_d   = instr_addr;

        // A byte on the expiry cycle wins: timeout is only taken on a silent cycle.
        if (timed && !bus.rx_valid) begin
            if (tmo == TIMEOUT_LAST) begin
                reply_d   = REPLY_TIMEOUT;
                loading_d = 1'b0;
                state_d   = S_RESPOND;
            end else begin
                tmo_d = tmo + 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    state_d = S_RESPOND;
                    reply_d = REPLY_OK;
                    case (bus.rx_data)
                        CMD_LOAD: begin
                            core_reset_d   = 1'b1;
                            core_running_d = 1'b0;
                            loading_d      = 1'b1;
                            csum_d         = '0;
                            state_d        = S_LEN_HI;
                        end
                        CMD_RUN: begin
                            core_reset_d   = 1'b0;
                            core_running_d = 1'b1;
                        end
                        CMD_STOP:   core_running_d = 1'b0;
                        CMD_RESET: begin
                            core_reset_d   = 1'b1;
                            core_running_d = 1'b0;
                        end
                        CMD_STATUS: reply_d = {6'b0, core_reset, bus.core_running_status};
                        default:    reply_d = REPLY_UNKNOWN;
                    endcase
                end
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_d   = {bus.rx_data, len[7:0]};
                    csum_d  = csum + bus.rx_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_d   = {len[15:8], bus.rx_data};
                    csum_d  = csum + bus.rx_data;
                    addr_d  = '0;
                    state_d = ({len[15:8], bus.rx_data} == 16'd0) ? S_CHECKSUM : S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (bus.rx_valid) begin
                    hi_nib_d = bus.rx_data[3:0];
                    csum_d   = csum + bus.rx_data;
                    state_d  = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (bus.rx_valid) begin
                    instr_d      = {hi_nib, bus.rx_data};
                    instr_addr_d = addr;
                    csum_d       = csum + bus.rx_data;
                    state_d      = S_WR_SETUP;
                end
            end
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: state_d = S_WR_HOLD;
            S_WR_HOLD: begin
                addr_d  = addr_inc;
                state_d = (addr_inc == len) ? S_CHECKSUM : S_DATA_HI;
            end
            S_CHECKSUM: begin
                if (bus.rx_valid) begin
                    reply_d   = (bus.rx_data == csum) ? REPLY_OK : REPLY_CSUM;
                    loading_d = 1'b0;
                    state_d   = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = reply;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.tx_start     = tx_start;
    assign bus.tx_data      = tx_data;
    assign bus.core_reset   = core_reset;
    assign bus.core_running = core_running;
    assign bus.loading      = loading;
    assign bus.instr        = instr;
    assign bus.instr_addr   = instr_addr;
    // Decoded from state so an asynchronous reset cuts the strobe at once.
    assign bus.instr_write  = (state == S_WR_PULSE);

endmodule

// File: tb/tb_blocpu_program_loader.sv
// tb/tb_blocpu_program_loader.sv - scoreboard bench for blocpu_program_loader
module tb_blocpu_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    blocpu_program_loader_if bus();

    blocpu_program_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [11:0] instr;
    } wr_t;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] reply_q[$];
    wr_t        wr_q[$];
    logic [7:0] frame[$];
    logic       prev_write = 1'b0;
    logic [7:0] exp_reply;
    wr_t        exp_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.tx_start) begin
                check("reply_expected", 32'(reply_q.size() != 0), 1);
                if (reply_q.size() != 0) begin
                    exp_reply = reply_q.pop_front();
                    check("reply_byte", bus.tx_data, exp_reply);
                end
            end
            if (bus.instr_write) begin
                check("write_not_back_to_back", prev_write, 0);
                check("write_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    exp_wr = wr_q.pop_front();
                    check("write_addr", bus.instr_addr, exp_wr.addr);
                    check("write_instr", bus.instr, exp_wr.instr);
                    check("write_core_reset", bus.core_reset, 1);
                end
            end
        end
        prev_write = bus.instr_write;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i], 4);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (reply_q.size() == 0 && wr_q.size() == 0) break;
            @(posedge clk);
        end
        check({tag, "_replies_left"}, reply_q.size(), 0);
        check({tag, "_writes_left"}, wr_q.size(), 0);
    endtask

    initial begin
        int  n;
        logic seen;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_busy  = 1'b0;
        bus.core_running_status = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_core_reset", bus.core_reset, 1);
        check("rst_core_running", bus.core_running, 0);
        check("rst_loading", bus.loading, 0);
        check("rst_instr_write", bus.instr_write, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_instr_addr", bus.instr_addr, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // happy-path load then RUN
        wr_q.push_back('{16'd0, 12'h800});
        wr_q.push_back('{16'd1, 12'h940});
        reply_q.push_back(8'h4B);
        send_byte(8'hA5, 0);
        check("load_loading_high", bus.loading, 1);
        check("load_core_reset", bus.core_reset, 1);
        frame = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h09, 8'h40, 8'h53};
        send_frame();
        wait_drain("load_ok");
        check("load_ok_loading_low", bus.loading, 0);
        check("load_ok_core_reset", bus.core_reset, 1);

        reply_q.push_back(8'h4B);
        send_byte(8'h52, 0);
        check("run_core_reset", bus.core_reset, 0);
        check("run_core_running", bus.core_running, 1);
        check("run_no_early_reply", bus.tx_start, 0);
        @(posedge clk); #1;
        check("run_reply_latency", bus.tx_start, 1);
        wait_drain("run");

        // bad checksum: writes still happen
        wr_q.push_back('{16'd0, 12'h800});
        wr_q.push_back('{16'd1, 12'h940});
        reply_q.push_back(8'h43);
        send_byte(8'hA5, 0);
        check("reload_core_reset", bus.core_reset, 1);
        check("reload_core_running", bus.core_running, 0);
        frame = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h09, 8'h40, 8'h00};
        send_frame();
        wait_drain("bad_csum");
        check("bad_csum_loading_low", bus.loading, 0);

        // hi[7:4] dropped from the word, checksum wraps to 0x00
        wr_q.push_back('{16'd0, 12'h35C});
        reply_q.push_back(8'h4B);
        send_byte(8'hA5, 0);
        frame = '{8'h00, 8'h01, 8'hA3, 8'h5C, 8'h00};
        send_frame();
        wait_drain("hi_nibble");

        // zero length and unknown command
        reply_q.push_back(8'h4B);
        send_byte(8'hA5, 0);
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame();
        wait_drain("zero_len");
        reply_q.push_back(8'h45);
        send_byte(8'h11, 0);
        wait_drain("unknown");

        // RUN, STOP, RESET
        reply_q.push_back(8'h4B);
        send_byte(8'h52, 0);
        wait_drain("run2");
        reply_q.push_back(8'h4B);
        send_byte(8'h53, 0);
        check("stop_core_running", bus.core_running, 0);
        check("stop_core_reset", bus.core_reset, 0);
        wait_drain("stop");
        reply_q.push_back(8'h4B);
        send_byte(8'h58, 0);
        check("reset_cmd_core_reset", bus.core_reset, 1);
        wait_drain("reset_cmd");

        // timeout after A5 00 03
        reply_q.push_back(8'h54);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        n = 0;
        while (n < 300 && !bus.tx_start) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_latency_window", 32'(n >= 99 && n <= 103), 1);
        wait_drain("timeout");
        check("timeout_loading_low", bus.loading, 0);
        check("timeout_core_reset", bus.core_reset, 1);

        // STATUS with a busy transmitter
        bus.tx_busy = 1'b1;
        reply_q.push_back(8'h02);
        send_byte(8'h3F, 0);
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.tx_start) seen = 1'b1;
        end
        check("status_held_while_busy", seen, 0);
        bus.tx_busy = 1'b0;
        @(posedge clk); #1;
        check("status_reply_after_busy", bus.tx_start, 1);
        wait_drain("status_busy");

        bus.core_running_status = 1'b1;
        reply_q.push_back(8'h03);
        send_byte(8'h3F, 0);
        wait_drain("status_running");
        bus.core_running_status = 1'b0;

        // async reset during the write strobe
        send_byte(8'hA5, 0);
        frame = '{8'h00, 8'h01, 8'h0A};
        send_frame();
        send_byte(8'hBC, 0);
        check("setup_no_strobe", bus.instr_write, 0);
        check("setup_instr", bus.instr, 12'hABC);
        check("setup_addr", bus.instr_addr, 0);
        @(posedge clk); #1;
        check("pulse_strobe", bus.instr_write, 1);
        reset = 1'b1;
        #1;
        check("async_rst_instr_write", bus.instr_write, 0);
        check("async_rst_core_reset", bus.core_reset, 1);
        check("async_rst_loading", bus.loading, 0);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.tx_start) seen = 1'b1;
        end
        check("no_reply_after_reset", seen, 0);
        reply_q.push_back(8'h02);
        send_byte(8'h3F, 0);
        wait_drain("status_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
